// File: rtl/pipe_ripple_adder.sv
// Pipelined ripple-carry adder: one SEG-bit carry segment per stage, valid/ready on both sides.
// Define PIPE_ADD_OVF_EN to add the registered signed-overflow output ovf.
module pipe_ripple_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
`ifdef PIPE_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int STAGES = WIDTH / SEG;
    localparam int LAST   = STAGES - 1;

    logic advance;

    logic [STAGES-1:0]            vld_q;
    logic [STAGES-1:0]            cry_q;
    logic [STAGES-1:0][WIDTH-1:0] res_q;
    logic [STAGES-1:0][WIDTH-1:0] opa_q;
    logic [STAGES-1:0][WIDTH-1:0] opb_q;

    // Inputs seen by stage s: entry 0 is the operand port, entry s>0 is register stage s-1.
    logic [STAGES-1:0]            lnk_v;
    logic [STAGES-1:0]            lnk_c;
    logic [STAGES-1:0][WIDTH-1:0] lnk_r;
    logic [STAGES-1:0][WIDTH-1:0] lnk_a;
    logic [STAGES-1:0][WIDTH-1:0] lnk_b;

    logic [STAGES-1:0]            cry_d;
    logic [STAGES-1:0][WIDTH-1:0] res_d;
    logic [SEG:0]                 seg_sum;

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_q[LAST];
    assign sum       = {cry_q[LAST], res_q[LAST]};

    always_comb begin
        lnk_v    = '0;
        lnk_c    = '0;
        lnk_r    = '0;
        lnk_a    = '0;
        lnk_b    = '0;
        lnk_v[0] = in_valid;
        lnk_c[0] = cin;
        lnk_a[0] = a;
        lnk_b[0] = b;
        for (int s = 1; s < STAGES; s++) begin
            lnk_v[s] = vld_q[s-1];
            lnk_c[s] = cry_q[s-1];
            lnk_r[s] = res_q[s-1];
            lnk_a[s] = opa_q[s-1];
            lnk_b[s] = opb_q[s-1];
        end
    end

    // Each stage resolves its own slice and passes lower resolved bits through unchanged.
    always_comb begin
        seg_sum = '0;
        res_d   = '0;
        cry_d   = '0;
        for (int s = 0; s < STAGES; s++) begin
            seg_sum = {1'b0, lnk_a[s][s*SEG +: SEG]} + {1'b0, lnk_b[s][s*SEG +: SEG]}
                    + {{SEG{1'b0}}, lnk_c[s]};
            res_d[s]               = lnk_r[s];
            res_d[s][s*SEG +: SEG] = seg_sum[SEG-1:0];
            cry_d[s]               = seg_sum[SEG];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            cry_q <= '0;
            res_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
        end else if (advance) begin
            vld_q <= lnk_v;
            cry_q <= cry_d;
            res_q <= res_d;
            opa_q <= lnk_a;
            opb_q <= lnk_b;
        end
    end

    // The final stage's operand copy has no consumer.
    logic unused_ops;
    assign unused_ops = ^{opa_q[LAST], opb_q[LAST]};

`ifdef PIPE_ADD_OVF_EN
    logic ovf_d;
    logic ovf_q;

    assign ovf_d = (lnk_a[LAST][WIDTH-1] == lnk_b[LAST][WIDTH-1])
                && (res_d[LAST][WIDTH-1] != lnk_a[LAST][WIDTH-1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipe_ripple_adder.sv
// Self-checking bench for pipe_ripple_adder: directed table, random streams against an
// arithmetic model, backpressure, bubbles and mid-flight reset.
module tb_pipe_ripple_adder;
    localparam int WIDTH  = 16;
    localparam int SEG    = 4;
    localparam int STAGES = WIDTH / SEG;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH:0]   sum;
        logic             ovf;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum;
`ifdef PIPE_ADD_OVF_EN
    logic             ovf;
`endif

    int checks   = 0;
    int failures = 0;
    int n_acc    = 0;
    int n_emit   = 0;
    int a0, e0, rdy_drops, stale;
    logic [WIDTH:0]   bp_exp;
    logic [WIDTH+1:0] exp_q[$];
    vec_t             vecs[8];

    pipe_ripple_adder #(
        .WIDTH(WIDTH),
        .SEG  (SEG)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum)
`ifdef PIPE_ADD_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH:0] model_sum(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                 input logic c);
        longint s = longint'(x) + longint'(y) + longint'(c);
        return (WIDTH+1)'(s);
    endfunction

    function automatic logic model_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                       input logic c);
        longint s = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        return (s > longint'(2**(WIDTH-1)) - 1) || (s < -longint'(2**(WIDTH-1)));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Scoreboard: inputs/outputs are stable at the falling edge and captured on the next rise.
    always @(negedge clk) begin
        logic [WIDTH+1:0] e;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_emit++;
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_sum", 32'(sum), 32'(e[WIDTH:0]));
`ifdef PIPE_ADD_OVF_EN
                    chk("stream_ovf", 32'(ovf), 32'(e[WIDTH+1]));
`endif
                end
            end
            if (in_valid && in_ready) begin
                n_acc++;
                exp_q.push_back({model_ovf(a, b, cin), model_sum(a, b, cin)});
            end
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int k = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (exp_q.size() != 0 && k < 50);
        chk(name, exp_q.size(), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        a        = v.a;
        b        = v.b;
        cin      = v.cin;
        in_valid = 1'b1;
        chk($sformatf("vec%0d_in_ready", idx), 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (STAGES - 2) @(posedge clk);
        #1;
        chk($sformatf("vec%0d_early", idx), 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d_valid", idx), 32'(out_valid), 32'd1);
        chk($sformatf("vec%0d_sum", idx), 32'(sum), 32'(v.sum));
`ifdef PIPE_ADD_OVF_EN
        chk($sformatf("vec%0d_ovf", idx), 32'(ovf), 32'(v.ovf));
`endif
    endtask

    initial begin
        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0};
        vecs[1] = '{16'h0000, 16'h0000, 1'b0, 17'h00000, 1'b0};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 1'b0};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 17'h10000, 1'b1};
        vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 17'h08000, 1'b1};
        vecs[5] = '{16'h1234, 16'h4321, 1'b1, 17'h05556, 1'b0};
        vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 17'h01000, 1'b0};
        vecs[7] = '{16'h0001, 16'hFFFF, 1'b0, 17'h10000, 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        reset = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end
        idle(2);

        // Back-to-back stream at full throughput.
        e0        = n_emit;
        rdy_drops = 0;
        for (int i = 0; i < 128; i++) begin
            a        = WIDTH'($urandom);
            b        = WIDTH'($urandom);
            cin      = 1'($urandom);
            in_valid = 1'b1;
            if (!in_ready) rdy_drops++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (STAGES) @(posedge clk);
        #1;
        chk("b2b_count", n_emit - e0, 32'd128);
        chk("b2b_ready_drops", rdy_drops, 32'd0);
        chk("b2b_queue", exp_q.size(), 32'd0);

        // Random valid and ready.
        a0 = n_acc;
        e0 = n_emit;
        for (int i = 0; i < 300; i++) begin
            a         = WIDTH'($urandom);
            b         = WIDTH'($urandom);
            cin       = 1'($urandom);
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        drain("rand_drain");
        chk("rand_count", n_emit - e0, n_acc - a0);

        // Backpressure: fill the pipe, then hold for 5 cycles.
        idle(1);
        a0        = n_acc;
        e0        = n_emit;
        out_ready = 1'b0;
        bp_exp    = '0;
        for (int i = 0; i < STAGES; i++) begin
            a        = WIDTH'($urandom);
            b        = WIDTH'($urandom);
            cin      = 1'($urandom);
            in_valid = 1'b1;
            if (i == 0) bp_exp = model_sum(a, b, cin);
            @(posedge clk);
            #1;
        end
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_first", 32'(sum), 32'(bp_exp));
        for (int i = 0; i < 5; i++) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            @(posedge clk);
            #1;
            chk("bp_hold_sum", 32'(sum), 32'(bp_exp));
            chk("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        drain("bp_drain");
        chk("bp_accepts", n_acc - a0, STAGES);
        chk("bp_emits", n_emit - e0, STAGES);

        // Bubbles: valid pattern 1,0,1 must reappear at the output.
        idle(1);
        a   = 16'd1;
        b   = 16'd2;
        cin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = (i != 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bub_valid%0d", i), 32'(out_valid), 32'(i != 1));
            if (i != 1) chk($sformatf("bub_sum%0d", i), 32'(sum), 32'(model_sum(16'd1, 16'd2, 1'b1)));
        end

        // Reset with three operands in flight.
        idle(2);
        for (int i = 0; i < 3; i++) begin
            a        = WIDTH'($urandom);
            b        = WIDTH'($urandom);
            cin      = 1'($urandom);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_pre_valid", 32'(out_valid), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_sum", 32'(sum), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_rel_ready", 32'(in_ready), 32'd1);
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
        end
        chk("rst_no_stale", stale, 32'd0);
        chk("final_queue", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
